// File: rtl/tone_synth_pkg.sv
// Shared definitions for the tone synthesis blocks: default phase width,
// default sample-rate divider ratio and the phase type used by the tone generators.
package tone_synth_pkg;

  localparam int DEFAULT_ACCUMULATOR_BITS = 24;
  localparam int DEFAULT_SAMPLE_CLK_DIV   = 1024;

  typedef logic [DEFAULT_ACCUMULATOR_BITS-1:0] phase_t;

endpackage : tone_synth_pkg

// File: rtl/sample_rate_divider.sv
// Free-running divider: counts 0..DIV-1 and flags the cycle whose rising edge
// is the sample boundary. Also reusable by the DAC/PWM output stage.
module sample_rate_divider #(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_en
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("sample_rate_divider: DIV must be >= 2");
  end

  logic [CNT_W-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_en = (div_cnt == LAST);

endmodule : sample_rate_divider

// File: rtl/tone_phase_accumulator.sv
// Phase accumulator for the tone generators, advanced once per audio sample.
// Optional macro TONE_PHASE_RESET_ON_NOTE_EN zeroes the phase when a new word applies.
module tone_phase_accumulator
  import tone_synth_pkg::*;
#(
  parameter int ACCUMULATOR_BITS = DEFAULT_ACCUMULATOR_BITS,
  parameter int SAMPLE_CLK_DIV   = DEFAULT_SAMPLE_CLK_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        gate,
  input  logic                        freq_valid,
  output logic                        freq_ready,
  input  logic [ACCUMULATOR_BITS-1:0] freq_word,
  output logic                        sample_tick,
  output logic [ACCUMULATOR_BITS-1:0] accumulator,
  output logic                        wrap
);

  logic                        tick_en;
  logic                        pending_valid;
  logic [ACCUMULATOR_BITS-1:0] pending_freq;
  logic [ACCUMULATOR_BITS-1:0] active_freq;
  logic [ACCUMULATOR_BITS-1:0] increment;
  logic [ACCUMULATOR_BITS:0]   sum;

  sample_rate_divider #(
    .DIV (SAMPLE_CLK_DIV)
  ) u_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en)
  );

  assign freq_ready = ~pending_valid;

  // A pending word takes effect on the very tick that retires it.
  assign increment = pending_valid ? pending_freq : active_freq;
  assign sum       = {1'b0, accumulator} + {1'b0, increment};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accumulator   <= '0;
      active_freq   <= '0;
      pending_freq  <= '0;
      pending_valid <= 1'b0;
      sample_tick   <= 1'b0;
      wrap          <= 1'b0;
    end else begin
      sample_tick <= tick_en;
      wrap        <= 1'b0;
      if (tick_en) begin
        if (pending_valid) begin
          active_freq   <= pending_freq;
          pending_valid <= 1'b0;
        end
        if (!gate) begin
          accumulator <= '0;
`ifdef TONE_PHASE_RESET_ON_NOTE_EN
        end else if (pending_valid) begin
          accumulator <= '0;
`endif
        end else begin
          {wrap, accumulator} <= sum;
        end
      end
      // Accept only when nothing is pending, so this never races the retire above.
      if (freq_valid && freq_ready) begin
        pending_freq  <= freq_word;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule : tone_phase_accumulator

// File: tb/tb_tone_phase_accumulator.sv
// Directed bench for tone_phase_accumulator with 8-bit phase and a divide-by-4 sample clock.
// Expectations follow TONE_PHASE_RESET_ON_NOTE_EN when the bench is built with it.
module tb_tone_phase_accumulator;

  localparam int AB  = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gate = 1'b1;
  logic          freq_valid = 1'b0;
  logic          freq_ready;
  logic [AB-1:0] freq_word = '0;
  logic          sample_tick;
  logic [AB-1:0] accumulator;
  logic          wrap;

  int vectors = 0;
  int miscompares = 0;

  tone_phase_accumulator #(
    .ACCUMULATOR_BITS (AB),
    .SAMPLE_CLK_DIV   (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gate        (gate),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .freq_word   (freq_word),
    .sample_tick (sample_tick),
    .accumulator (accumulator),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  // Holds reset for two edges; the next rising edge after return is cycle 1.
  task automatic apply_reset();
    rst_n      = 1'b0;
    freq_valid = 1'b0;
    gate       = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Advances to the cycle in which sample_tick is high, bounded by two periods.
  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(posedge clk); #1;
      if (sample_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_tick_timeout: no sample_tick within %0d cycles", tag, 2 * DIV);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gate  = 1'b1;
    #1;
    vectors++;
    if ({accumulator, sample_tick, wrap, freq_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: acc=%h tick=%b wrap=%b ready=%b, want acc=00 tick=0 wrap=0 ready=1",
               accumulator, sample_tick, wrap, freq_ready);
    end
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (sample_tick !== (k % DIV == 0) || accumulator !== 8'h00 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: tick=%b acc=%h wrap=%b, want tick=%b acc=00 wrap=0",
                 k, sample_tick, accumulator, wrap, (k % DIV == 0));
      end
    end
  endtask

  // Loads 0x40 before the first tick; leaves the bench just after the 0x00 tick.
  task automatic test_sweep();
    logic [AB-1:0] exp_acc [4] = '{8'h40, 8'h80, 8'hC0, 8'h00};
    logic          exp_wrap[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    freq_valid = 1'b1;
    freq_word  = 8'h40;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    vectors++;
    if (freq_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_pending_ready: ready=%b, want 0", freq_ready);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick("sweep");
      vectors++;
      if (accumulator !== exp_acc[i] || wrap !== exp_wrap[i] || freq_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_step%0d: acc=%h wrap=%b ready=%b, want acc=%h wrap=%b ready=1",
                 i, accumulator, wrap, freq_ready, exp_acc[i], exp_wrap[i]);
      end
    end
  endtask

  // Offers 0x10 so the transfer lands on a tick edge while running 0x40 from 0x00.
  task automatic test_tick_edge_transfer();
    repeat (DIV - 1) begin
      @(posedge clk); #1;
    end
    freq_valid = 1'b1;
    freq_word  = 8'h10;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    vectors++;
    if (sample_tick !== 1'b1 || accumulator !== 8'h40 || freq_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_xfer_tick: tick=%b acc=%h ready=%b, want tick=1 acc=40 ready=0",
               sample_tick, accumulator, freq_ready);
    end
    for (int k = 1; k <= DIV; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (freq_ready !== (k == DIV) || sample_tick !== (k == DIV)) begin
        miscompares++;
        $display("FAIL edge_xfer_ready%0d: ready=%b tick=%b, want ready=%b tick=%b",
                 k, freq_ready, sample_tick, (k == DIV), (k == DIV));
      end
    end
    vectors++;
    if (accumulator !== 8'h50) begin
      miscompares++;
      $display("FAIL edge_xfer_apply: acc=%h, want 50", accumulator);
    end
  endtask

  // From acc=0x50 just after a tick: 0x20 accepted, 0x30 stalls until 0x20 retires.
  task automatic test_back_to_back();
    freq_valid = 1'b1;
    freq_word  = 8'h20;
    @(posedge clk); #1;
    freq_word = 8'h30;
    for (int k = 0; k < DIV - 2; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (freq_ready !== 1'b0 || sample_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_stall%0d: ready=%b tick=%b, want ready=0 tick=0", k, freq_ready, sample_tick);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (sample_tick !== 1'b1 || accumulator !== 8'h70 || freq_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_apply: tick=%b acc=%h ready=%b, want tick=1 acc=70 ready=1",
               sample_tick, accumulator, freq_ready);
    end
    @(posedge clk); #1;
    freq_valid = 1'b0;
    vectors++;
    if (freq_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second_accept: ready=%b, want 0", freq_ready);
    end
    wait_tick("b2b");
    vectors++;
    if (accumulator !== 8'hA0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second_apply: acc=%h wrap=%b, want acc=A0 wrap=0", accumulator, wrap);
    end
  endtask

  task automatic test_gate();
    logic [AB-1:0] exp_acc[5] = '{8'h40, 8'h80, 8'h00, 8'h40, 8'h80};
    apply_reset();
    freq_valid = 1'b1;
    freq_word  = 8'h40;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_tick("gate");
      vectors++;
      if (accumulator !== exp_acc[i] || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL gate_step%0d: acc=%h wrap=%b, want acc=%h wrap=0", i, accumulator, wrap, exp_acc[i]);
      end
      gate = (i != 1);
    end
  endtask

  // Pending word must be lost on an asynchronous mid-operation reset.
  task automatic test_mid_reset();
    freq_valid = 1'b1;
    freq_word  = 8'h10;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (accumulator !== 8'h00 || freq_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_async: acc=%h ready=%b, want acc=00 ready=1", accumulator, freq_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_tick("midreset");
    vectors++;
    if (accumulator !== 8'h00 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_pending: acc=%h wrap=%b, want acc=00 wrap=0", accumulator, wrap);
    end
  endtask

  task automatic test_note_change();
`ifdef TONE_PHASE_RESET_ON_NOTE_EN
    logic [AB-1:0] exp_acc [6] = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h20, 8'h40};
    logic          exp_wrap[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic [AB-1:0] exp_acc [6] = '{8'h40, 8'h80, 8'hC0, 8'hE0, 8'h00, 8'h20};
    logic          exp_wrap[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    apply_reset();
    freq_valid = 1'b1;
    freq_word  = 8'h40;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_tick("note");
      vectors++;
      if (accumulator !== exp_acc[i] || wrap !== exp_wrap[i]) begin
        miscompares++;
        $display("FAIL note_step%0d: acc=%h wrap=%b, want acc=%h wrap=%b",
                 i, accumulator, wrap, exp_acc[i], exp_wrap[i]);
      end
      if (i == 2) begin
        freq_valid = 1'b1;
        freq_word  = 8'h20;
        @(posedge clk); #1;
        freq_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_tick_edge_transfer();
    test_back_to_back();
    test_gate();
    test_mid_reset();
    test_note_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tone_phase_accumulator

// File: doc/tone_phase_accumulator.md
Name: tone_phase_accumulator

Overview:
- Drives the `accumulator` phase input consumed by the tone generators (sine LUT, square, saw).
- Holds a frequency tuning word and divides the system clock down to the audio sample rate.
- On each sample tick, advances the phase by the tuning word, modulo 2^ACCUMULATOR_BITS.
- Frequency updates arrive over a valid/ready handshake and take effect only on sample boundaries, so the waveform never glitches mid-sample.

Parameters:
- ACCUMULATOR_BITS, 24: width of the phase accumulator and the tuning word.
- SAMPLE_CLK_DIV, 1024: system clocks per audio sample. Must be >= 2; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gate  input  1  1 = tone running; 0 = phase forced to 0 at each tick.
- freq_valid  input  1  tuning word offered.
- freq_ready  output  1  block can accept a tuning word.
- freq_word  input  ACCUMULATOR_BITS  phase increment per sample.
- sample_tick  output  1  one-cycle pulse: `accumulator` has just taken a new value.
- accumulator  output  ACCUMULATOR_BITS  registered phase, feeds tone generators.
- wrap  output  1  one-cycle pulse, coincident with sample_tick, when the phase add carried out (one full period completed).

Behaviour:
- Reset (async assert, sync release): div_cnt=0, accumulator=0, active_freq=0, pending_valid=0, sample_tick=0, wrap=0. freq_ready=1 from the first cycle after reset.
- Divider: div_cnt counts 0..SAMPLE_CLK_DIV-1 and wraps to 0. The "tick edge" is the clock edge at which div_cnt == SAMPLE_CLK_DIV-1.
  - sample_tick and wrap are registered; they are high for exactly the cycle after the tick edge.
  - First sample_tick is high in cycle SAMPLE_CLK_DIV after reset release, counting from cycle 1.
- Frequency handshake:
  - freq_ready = ~pending_valid.
  - Transfer happens when freq_valid && freq_ready at an edge; freq_word is captured into pending_freq and pending_valid is set.
  - At the tick edge, if pending_valid: active_freq <= pending_freq and pending_valid is cleared.
  - The increment used at a tick edge is the new pending_freq if one was pending, else active_freq. The new word therefore affects the very tick that applies it.
  - A transfer that occurs on the tick edge itself is captured into pending and applies at the following tick.
  - freq_word is ignored while freq_ready=0. Only one word can be pending; further offers stall.
- Phase update at the tick edge:
  - gate=1: {carry, accumulator} <= accumulator + increment, unsigned, modulo 2^ACCUMULATOR_BITS. wrap <= carry.
  - gate=0: accumulator <= 0, wrap <= 0. Pending frequencies are still applied.
- Between tick edges, accumulator holds.
- Tuning word of 0 holds the phase constant.
- Latency: a word accepted at edge E is visible in accumulator after the first tick edge strictly after E.
- Mid-operation reset clears everything immediately, including any pending word.
- div_cnt runs continuously regardless of gate or handshake.

Optional Feature:
- Macro: TONE_PHASE_RESET_ON_NOTE_EN.
- Defined: at a tick edge that applies a pending word with gate=1, accumulator <= 0 instead of adding, and wrap <= 0. This gives phase-aligned note starts.
- Undefined: phase is continuous across frequency changes; the new increment is simply added.

Decomposition:
- Shared package tone_synth_pkg: ACCUMULATOR_BITS default, the phase_t typedef (logic [ACCUMULATOR_BITS-1:0]), and the default SAMPLE_CLK_DIV. The tone generators use the same package.
- One natural sub-module: sample_rate_divider (div_cnt plus a tick-edge enable output), reusable by the output DAC/PWM stage.

Test Plan (bench uses ACCUMULATOR_BITS=8, SAMPLE_CLK_DIV=4):
- Reset, gate=1, no words -> accumulator stays 0x00. sample_tick pulses every 4 cycles, first in cycle 4. wrap never asserts.
- Word 0x40 accepted before first tick, gate=1 -> accumulator reads 0x40, 0x80, 0xC0, 0x00 on successive ticks. wrap=1 only with the 0x00 tick.
- Word 0x10 accepted exactly on a tick edge while running 0x40 -> that tick adds 0x40. Next tick adds 0x10. freq_ready low for exactly one sample period.
- Second word offered while one is pending -> freq_ready=0 and the offer stalls. The second word is accepted the cycle after the tick that drains pending.
- gate dropped at accumulator=0x80 -> next tick gives 0x00. Re-raising gate resumes with 0x40 steps from 0x00.
- With TONE_PHASE_RESET_ON_NOTE_EN, new word 0x20 applied at accumulator=0xC0 -> that tick gives 0x00, then 0x20, 0x40.
- Without the macro, the same stimulus gives 0xE0, 0x00 (wrap=1).
